// File: rtl/mem_stage_buffer.sv
// MEM stage: takes EX/MEM entries, runs the data-memory req/ack access, emits registered MEM/WB entries.
// state | meaning
// IDLE  | accepting entries; non-memory entries retire in one cycle
// WAIT  | memory access outstanding; upstream stalled, mem_req held high
module mem_stage_buffer #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ALU_Result_in,
    input  logic [DW-1:0] ALU_Remainder_in,
    input  logic [DW-1:0] Store_Data_in,
    input  logic [3:0]    movOp_in,
    input  logic [3:0]    Rd_in,
    input  logic          MemtoReg_in,
    input  logic          MemWrite_in,
    input  logic          MemRead_in,
    input  logic          R15_in,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_valid,
    output logic [DW-1:0] WB_Data,
    output logic [DW-1:0] WB_Remainder,
    output logic [3:0]    WB_Rd,
    output logic [3:0]    WB_movOp,
    output logic          RegWrite_out,
    output logic          R15_out,
    output logic          mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic          r_l_read;
    logic          r_l_store;
    logic          r_l_m2r;
    logic          r_l_r15;
    logic [DW-1:0] r_l_rem;
    logic [3:0]    r_l_rd;
    logic [3:0]    r_l_mov;
    logic          w_memop;

    assign w_memop = MemRead_in | MemWrite_in;
    assign stall   = (r_state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_l_read     <= 1'b0;
            r_l_store    <= 1'b0;
            r_l_m2r      <= 1'b0;
            r_l_r15      <= 1'b0;
            r_l_rem      <= '0;
            r_l_rd       <= '0;
            r_l_mov      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            WB_Data      <= '0;
            WB_Remainder <= '0;
            WB_Rd        <= '0;
            WB_movOp     <= '0;
            RegWrite_out <= 1'b0;
            R15_out      <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ex_valid && !w_memop) begin
                        WB_Data      <= ALU_Result_in;
                        WB_Remainder <= ALU_Remainder_in;
                        WB_Rd        <= Rd_in;
                        WB_movOp     <= movOp_in;
                        R15_out      <= R15_in;
                        RegWrite_out <= 1'b1;
                        wb_valid     <= 1'b1;
                    end else if (ex_valid) begin
                        // read+write together behaves as a write; the ALU result is written back
                        mem_addr  <= ALU_Result_in;
                        mem_wdata <= Store_Data_in;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in;
                        r_l_read  <= MemRead_in & ~MemWrite_in;
                        r_l_store <= MemWrite_in & ~MemRead_in;
                        r_l_m2r   <= MemtoReg_in & ~MemWrite_in;
                        r_l_r15   <= R15_in;
                        r_l_rem   <= ALU_Remainder_in;
                        r_l_rd    <= Rd_in;
                        r_l_mov   <= movOp_in;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        WB_Data      <= (r_l_read && r_l_m2r) ? mem_rdata : mem_addr;
                        WB_Remainder <= r_l_rem;
                        WB_Rd        <= r_l_rd;
                        WB_movOp     <= r_l_mov;
                        R15_out      <= r_l_r15;
                        RegWrite_out <= ~r_l_store;
                        wb_valid     <= 1'b1;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        // abort: retire a harmless entry so the pipeline keeps moving
                        WB_Data      <= '0;
                        WB_Remainder <= r_l_rem;
                        WB_Rd        <= r_l_rd;
                        WB_movOp     <= r_l_mov;
                        R15_out      <= 1'b0;
                        RegWrite_out <= 1'b0;
                        wb_valid     <= 1'b1;
                        mem_err      <= 1'b1;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_buffer.sv
// Directed self-checking bench for mem_stage_buffer: vector table for pass-through entries,
// hand sequences for load/store/timeout/reset corner cases.
module tb_mem_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ALU_Result_in, ALU_Remainder_in, Store_Data_in;
    logic [3:0]  movOp_in, Rd_in;
    logic        MemtoReg_in, MemWrite_in, MemRead_in, R15_in;
    logic        stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [15:0] WB_Data, WB_Remainder;
    logic [3:0]  WB_Rd, WB_movOp;
    logic        RegWrite_out, R15_out, mem_err;

    int checks   = 0;
    int failures = 0;
    int nw;

    mem_stage_buffer #(.DW(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .ALU_Result_in(ALU_Result_in), .ALU_Remainder_in(ALU_Remainder_in),
        .Store_Data_in(Store_Data_in), .movOp_in(movOp_in), .Rd_in(Rd_in),
        .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .R15_in(R15_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_valid(wb_valid), .WB_Data(WB_Data),
        .WB_Remainder(WB_Remainder), .WB_Rd(WB_Rd), .WB_movOp(WB_movOp),
        .RegWrite_out(RegWrite_out), .R15_out(R15_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] rem;
        logic [3:0]  mov;
        logic [3:0]  rd;
        logic        r15;
        logic [15:0] exp_data;
        logic [15:0] exp_rem;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_mov;
        logic        exp_r15;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_entry(input logic v, input logic [15:0] alu, input logic [15:0] rem,
                             input logic [15:0] sd, input logic [3:0] mov, input logic [3:0] rd,
                             input logic m2r, input logic mw, input logic mr, input logic r15);
        ex_valid = v; ALU_Result_in = alu; ALU_Remainder_in = rem; Store_Data_in = sd;
        movOp_in = mov; Rd_in = rd; MemtoReg_in = m2r; MemWrite_in = mw; MemRead_in = mr;
        R15_in = r15;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_WB_Data"}, WB_Data, 0);
        chk({tag, "_WB_Remainder"}, WB_Remainder, 0);
        chk({tag, "_WB_Rd"}, WB_Rd, 0);
        chk({tag, "_WB_movOp"}, WB_movOp, 0);
        chk({tag, "_RegWrite_out"}, RegWrite_out, 0);
        chk({tag, "_R15_out"}, R15_out, 0);
        chk({tag, "_mem_err"}, mem_err, 0);
    endtask

    // Called at the negedge of the first WAIT cycle; returns at the negedge after WAIT ends.
    task automatic run_mem(input int ack_at, input logic [15:0] rdata, input logic [15:0] exp_addr,
                           input logic exp_we, input logic [15:0] exp_wdata, output int nwait);
        nwait = 0;
        while (stall && nwait < 40) begin
            nwait++;
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_addr", mem_addr, exp_addr);
            chk("wait_mem_we", mem_we, exp_we);
            chk("wait_mem_wdata", mem_wdata, exp_wdata);
            chk("wait_wb_valid", wb_valid, 0);
            if (nwait == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 16'h0;
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h0007, 4'h0, 4'h3, 1'b1, 16'h1234, 16'h0007, 4'h3, 4'h0, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0000, 4'hA, 4'hF, 1'b0, 16'hFFFF, 16'h0000, 4'hF, 4'hA, 1'b0};
        vecs[2] = '{16'h0000, 16'h8001, 4'h5, 4'h0, 1'b1, 16'h0000, 16'h8001, 4'h0, 4'h5, 1'b1};
        vecs[3] = '{16'h00C3, 16'h1111, 4'h9, 4'h7, 1'b0, 16'h00C3, 16'h1111, 4'h7, 4'h9, 1'b0};

        set_entry(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_ack = 0; mem_rdata = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("init_rst");
        rst = 1'b0;
        @(negedge clk);

        // back-to-back non-memory entries, one per cycle
        for (int i = 0; i < 4; i++) begin
            set_entry(1, vecs[i].alu, vecs[i].rem, 16'h0, vecs[i].mov, vecs[i].rd, 0, 0, 0, vecs[i].r15);
            @(negedge clk);
            chk($sformatf("vec%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("vec%0d_WB_Data", i), WB_Data, vecs[i].exp_data);
            chk($sformatf("vec%0d_WB_Remainder", i), WB_Remainder, vecs[i].exp_rem);
            chk($sformatf("vec%0d_WB_Rd", i), WB_Rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_WB_movOp", i), WB_movOp, vecs[i].exp_mov);
            chk($sformatf("vec%0d_R15_out", i), R15_out, vecs[i].exp_r15);
            chk($sformatf("vec%0d_RegWrite", i), RegWrite_out, 1);
            chk($sformatf("vec%0d_stall", i), stall, 0);
        end
        ex_valid = 0;
        @(negedge clk);
        chk("idle_wb_valid_drop", wb_valid, 0);
        chk("idle_WB_Data_hold", WB_Data, 16'h00C3);

        // load, ack in 3rd WAIT cycle
        set_entry(1, 16'h0040, 16'h0011, 16'h0000, 4'h2, 4'h5, 1, 0, 1, 0);
        @(negedge clk);
        ex_valid = 0;
        chk("load_accept_no_wb", wb_valid, 0);
        run_mem(3, 16'hBEEF, 16'h0040, 0, 16'h0000, nw);
        chk("load_wait_cycles", nw, 3);
        chk("load_wb_valid", wb_valid, 1);
        chk("load_WB_Data", WB_Data, 16'hBEEF);
        chk("load_WB_Rd", WB_Rd, 4'h5);
        chk("load_WB_Remainder", WB_Remainder, 16'h0011);
        chk("load_RegWrite", RegWrite_out, 1);
        chk("load_mem_req_drop", mem_req, 0);
        @(negedge clk);
        chk("load_wb_pulse_one", wb_valid, 0);
        chk("load_WB_Data_hold", WB_Data, 16'hBEEF);

        // store, ack in 1st WAIT cycle; next non-memory entry held by stall
        set_entry(1, 16'h0020, 16'h0000, 16'hA5A5, 4'h0, 4'h1, 0, 1, 0, 0);
        @(negedge clk);
        set_entry(1, 16'h5555, 16'h0002, 16'h0000, 4'h3, 4'h6, 0, 0, 0, 0);
        run_mem(1, 16'h0000, 16'h0020, 1, 16'hA5A5, nw);
        chk("store_wait_cycles", nw, 1);
        chk("store_wb_valid", wb_valid, 1);
        chk("store_RegWrite", RegWrite_out, 0);
        chk("store_mem_we_drop", mem_we, 0);
        @(negedge clk);
        ex_valid = 0;
        chk("held_wb_valid", wb_valid, 1);
        chk("held_WB_Data", WB_Data, 16'h5555);
        chk("held_WB_Rd", WB_Rd, 4'h6);
        chk("held_RegWrite", RegWrite_out, 1);

        // ack while idle is ignored
        mem_ack = 1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        chk("idle_ack_wb_valid", wb_valid, 0);
        chk("idle_ack_stall", stall, 0);
        chk("idle_ack_mem_req", mem_req, 0);

        // timeout: load without ack
        set_entry(1, 16'h0080, 16'h0000, 16'h0000, 4'h0, 4'h2, 1, 0, 1, 1);
        @(negedge clk);
        ex_valid = 0;
        run_mem(0, 16'h0000, 16'h0080, 0, 16'h0000, nw);
        chk("to_wait_cycles", nw, 15);
        chk("to_mem_req", mem_req, 0);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_WB_Data", WB_Data, 0);
        chk("to_RegWrite", RegWrite_out, 0);
        chk("to_R15_out", R15_out, 0);
        chk("to_mem_err", mem_err, 1);
        @(negedge clk);
        chk("to_mem_err_sticky", mem_err, 1);
        chk("to_wb_pulse_one", wb_valid, 0);

        // later load completes normally, mem_err stays set
        set_entry(1, 16'h0090, 16'h0000, 16'h0000, 4'h0, 4'h4, 1, 0, 1, 0);
        @(negedge clk);
        ex_valid = 0;
        run_mem(2, 16'h1357, 16'h0090, 0, 16'h0000, nw);
        chk("post_to_wait_cycles", nw, 2);
        chk("post_to_WB_Data", WB_Data, 16'h1357);
        chk("post_to_wb_valid", wb_valid, 1);
        chk("post_to_mem_err", mem_err, 1);

        // read+write together: write performed, MemtoReg forced 0
        set_entry(1, 16'h0100, 16'h0000, 16'h00FF, 4'h0, 4'h8, 1, 1, 1, 0);
        @(negedge clk);
        ex_valid = 0;
        run_mem(1, 16'hDEAD, 16'h0100, 1, 16'h00FF, nw);
        chk("rw_wait_cycles", nw, 1);
        chk("rw_WB_Data", WB_Data, 16'h0100);
        chk("rw_wb_valid", wb_valid, 1);

        // reset mid-stream for 3 cycles
        set_entry(1, 16'h4242, 16'h0001, 16'h0000, 4'h1, 4'h2, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst_async");
        ex_valid = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        @(negedge clk);

        // async reset in the middle of WAIT
        set_entry(1, 16'h0200, 16'h0000, 16'h0000, 4'h0, 4'h3, 1, 0, 1, 0);
        @(negedge clk);
        ex_valid = 0;
        chk("rw_wait_entered", stall, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("wait_rst_mem_req", mem_req, 0);
        chk("wait_rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_wb_valid", wb_valid, 0);
        @(negedge clk);
        chk("wait_rst_after_wb_valid", wb_valid, 0);
        chk("wait_rst_after_stall", stall, 0);

        // recovers after reset
        set_entry(1, 16'h7777, 16'h0003, 16'h0000, 4'h4, 4'h9, 0, 0, 0, 0);
        @(negedge clk);
        ex_valid = 0;
        chk("recover_wb_valid", wb_valid, 1);
        chk("recover_WB_Data", WB_Data, 16'h7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_buffer.md
Name: mem_stage_buffer

Overview:
- Consumer end of the EX/MEM pipeline register, i.e. the MEM stage.
- Accepts one EX/MEM entry per cycle and performs the data-memory access over a req/ack handshake, stalling upstream while the access is outstanding.
- Produces the registered MEM/WB outputs for writeback: result, R15 remainder write and movOp passthrough.

Parameters:
- DW, 16, data/address width.
- TIMEOUT, 15, maximum WAIT cycles without mem_ack before abort (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  EX/MEM entry present.
- ALU_Result_in  in  DW  ALU result; also the memory word address.
- ALU_Remainder_in  in  DW  remainder, destined for R15.
- Store_Data_in  in  DW  store data.
- movOp_in  in  4  MOV sub-op, passed through.
- Rd_in  in  4  destination register.
- MemtoReg_in, MemWrite_in, MemRead_in, R15_in  in  1 each  control bits.
- stall  out  1  upstream must hold its entry while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DW  address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- wb_valid  out  1  one-cycle pulse, MEM/WB entry valid.
- WB_Data  out  DW  writeback value.
- WB_Remainder  out  DW  R15 value.
- WB_Rd  out  4  destination register.
- WB_movOp  out  4  MOV sub-op.
- RegWrite_out  out  1  writeback enable.
- R15_out  out  1  R15 write enable.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; wb_valid=0; mem_err=0; timeout counter=0.
- FSM has two states, IDLE and WAIT. stall = (state==WAIT), combinational.
- IDLE, ex_valid=1, no memory op (MemRead=MemWrite=0):
  - Register MEM/WB next edge: WB_Data=ALU_Result_in, WB_Remainder=ALU_Remainder_in, WB_Rd, WB_movOp, R15_out=R15_in, RegWrite_out=1.
  - wb_valid=1 for one cycle. Latency 1. Stay IDLE.
  - Back-to-back non-memory entries sustain 1 per cycle.
- IDLE, ex_valid=1, memory op:
  - Latch addr=ALU_Result_in, wdata=Store_Data_in, the control bits, Rd, movOp and remainder.
  - Go to WAIT. No wb_valid this cycle.
- MemRead and MemWrite both set: treated as a write, and MemtoReg is forced to 0 for that entry.
- WAIT:
  - mem_req=1 (registered), mem_we=latched MemWrite, mem_addr and mem_wdata stable for the whole of WAIT.
  - The counter increments each WAIT cycle without ack.
- mem_ack=1 in WAIT:
  - At that edge, register the MEM/WB entry. WB_Data = mem_rdata if (read and MemtoReg), else the latched ALU result.
  - RegWrite_out = 0 for a pure store, else 1.
  - wb_valid pulses next cycle; mem_req drops next cycle; return to IDLE; counter cleared.
  - Ack in the first WAIT cycle is legal. Total latency = 1 + N, where N = WAIT cycles up to and including the ack.
- Timeout (counter reaches TIMEOUT with no ack):
  - Drop mem_req and return to IDLE.
  - Set mem_err (sticky until reset). wb_valid pulses with WB_Data=0 and RegWrite_out=0, R15_out=0.
- mem_ack while IDLE: ignored.
- ex_valid while in WAIT: not sampled; upstream holds. It is accepted in the first IDLE cycle.
- Reset during WAIT: mem_req deasserts immediately (async); the in-flight entry is discarded and no wb_valid is produced.
- WB_* outputs hold their last value between wb_valid pulses.

Test Plan:
1. Reset check: assert rst for 3 cycles mid-stream -> all outputs 0, stall=0, mem_err=0.
2. Non-memory entry: ALU_Result=0x1234, R15_in=1, Remainder=0x0007, Rd=3 -> next cycle wb_valid=1, WB_Data=0x1234, WB_Remainder=0x0007, R15_out=1, RegWrite_out=1, stall never high.
3. Load with ack on the 3rd WAIT cycle: addr 0x0040, MemRead=1, MemtoReg=1, mem_rdata=0xBEEF -> mem_req high 3 cycles, mem_addr=0x0040, stall high 3 cycles, then wb_valid with WB_Data=0xBEEF.
4. Store with ack on the 1st WAIT cycle: MemWrite=1, Store_Data=0xA5A5 -> mem_we=1, mem_wdata=0xA5A5, wb_valid with RegWrite_out=0. A following non-memory entry is held by stall and then completes the cycle after.
5. No-ack timeout: TIMEOUT=15, load with no ack -> mem_req drops after 15 WAIT cycles, mem_err=1 stays set, wb_valid with RegWrite_out=0. A later load with ack completes normally while mem_err remains 1.
6. Edge cases: both MemRead and MemWrite set -> write performed, MemtoReg forced 0. Async reset asserted mid-WAIT -> mem_req drops the same cycle, no wb_valid.
